// File: rtl/radix2_fft_stream.sv
`default_nettype none
// ============================================================================
// radix2_fft_stream : in-place iterative radix-2 DIT FFT, streamed load/unload
// Option FFT_STAGE_SCALE_EN : halve every butterfly output (no saturation).
// Rev 1.0
// ============================================================================
module radix2_fft_stream #(
    parameter int W     = 16,
    parameter int LOG2N = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_real,
    input  logic [W-1:0]     in_imag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_real,
    output logic [W-1:0]     out_imag,
    output logic [LOG2N-1:0] out_index,
    output logic             out_last,
    output logic             ovf
);
    localparam int AW = LOG2N;
    localparam int N  = 1 << LOG2N;
    localparam logic [AW-1:0] ONE        = AW'(1);
    localparam logic [AW-1:0] LAST_N     = AW'(N - 1);
    localparam logic [AW-1:0] LAST_J     = AW'(N / 2 - 1);
    localparam logic [1:0]    LAST_STAGE = 2'(LOG2N - 1);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_UNLOAD  = 2'd2
    } state_t;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        for (int i = 0; i < AW; i++) bitrev[i] = v[AW-1-i];
    endfunction

    // First half of the 16-point Q1.14 twiddle table; k < N/2 never reaches idx 8+.
    function automatic logic signed [15:0] cos_tab(input logic [2:0] i);
        case (i)
            3'd0:    cos_tab =  16'sd16384;
            3'd1:    cos_tab =  16'sd15137;
            3'd2:    cos_tab =  16'sd11585;
            3'd3:    cos_tab =  16'sd6270;
            3'd4:    cos_tab =  16'sd0;
            3'd5:    cos_tab = -16'sd6270;
            3'd6:    cos_tab = -16'sd11585;
            default: cos_tab = -16'sd15137;
        endcase
    endfunction

    function automatic logic signed [15:0] sin_tab(input logic [2:0] i);
        case (i)
            3'd0:    sin_tab = 16'sd0;
            3'd1:    sin_tab = 16'sd6270;
            3'd2:    sin_tab = 16'sd11585;
            3'd3:    sin_tab = 16'sd15137;
            3'd4:    sin_tab = 16'sd16384;
            3'd5:    sin_tab = 16'sd15137;
            3'd6:    sin_tab = 16'sd11585;
            default: sin_tab = 16'sd6270;
        endcase
    endfunction

`ifdef FFT_STAGE_SCALE_EN
    function automatic logic [W:0] narrow(input logic signed [W+1:0] v);
        narrow = {1'b0, W'(v >>> 1)};
    endfunction
`else
    localparam logic signed [W+1:0] SAT_MAX = (W+2)'((1 << (W - 1)) - 1);
    localparam logic signed [W+1:0] SAT_MIN = ~SAT_MAX;

    // MSB of the result flags a clip.
    function automatic logic [W:0] narrow(input logic signed [W+1:0] v);
        if (v > SAT_MAX)      narrow = {1'b1, W'(SAT_MAX)};
        else if (v < SAT_MIN) narrow = {1'b1, W'(SAT_MIN)};
        else                  narrow = {1'b0, W'(v)};
    endfunction
`endif

    state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d, j_q, j_d, out_index_q, out_index_d;
    logic [1:0]    stage_q, stage_d;
    logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d, ovf_q, ovf_d;
    logic [W-1:0]  out_real_q, out_real_d, out_imag_q, out_imag_d;
    logic signed [W-1:0] re_q [N], re_d [N], im_q [N], im_d [N];

    logic [AW-1:0]        span, lo_mask, bf_lo, bf_top, bf_bot, bf_k;
    logic [2:0]           tw_idx;
    logic signed [15:0]   tw_re, tw_im;
    logic signed [W+16:0] br_x, bi_x, wr_x, wi_x, prod_re, prod_im;
    logic signed [W+1:0]  a_re, a_im, t_re, t_im;
    logic [W:0]           top_re, top_im, bot_re, bot_im;
    logic                 bf_clip;

    always_comb begin
        span    = ONE << stage_q;
        lo_mask = span - ONE;
        bf_lo   = j_q & lo_mask;
        bf_top  = ((j_q & ~lo_mask) << 1) | bf_lo;
        bf_bot  = bf_top | span;
        bf_k    = bf_lo << (LAST_STAGE - stage_q);
        tw_idx  = 3'(bf_k) << (4 - LOG2N);
        tw_re   = cos_tab(tw_idx);
        tw_im   = -sin_tab(tw_idx);
        br_x    = (W+17)'(re_q[bf_bot]);
        bi_x    = (W+17)'(im_q[bf_bot]);
        wr_x    = (W+17)'(tw_re);
        wi_x    = (W+17)'(tw_im);
        prod_re = br_x * wr_x - bi_x * wi_x;
        prod_im = br_x * wi_x + bi_x * wr_x;
        t_re    = (W+2)'(prod_re >>> 14);
        t_im    = (W+2)'(prod_im >>> 14);
        a_re    = (W+2)'(re_q[bf_top]);
        a_im    = (W+2)'(im_q[bf_top]);
        top_re  = narrow(a_re + t_re);
        top_im  = narrow(a_im + t_im);
        bot_re  = narrow(a_re - t_re);
        bot_im  = narrow(a_im - t_im);
        bf_clip = top_re[W] | top_im[W] | bot_re[W] | bot_im[W];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        j_d         = j_q;
        stage_d     = stage_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_index_d = out_index_q;
        out_real_d  = out_real_q;
        out_imag_d  = out_imag_q;
        ovf_d       = ovf_q;
        re_d        = re_q;
        im_d        = im_q;
        case (state_q)
            S_LOAD: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    re_d[bitrev(cnt_q)] = in_real;
                    im_d[bitrev(cnt_q)] = in_imag;
                    if (cnt_q == '0) ovf_d = 1'b0;
                    if (cnt_q == LAST_N) begin
                        cnt_d      = '0;
                        in_ready_d = 1'b0;
                        state_d    = S_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            S_COMPUTE: begin
                re_d[bf_top] = top_re[W-1:0];
                im_d[bf_top] = top_im[W-1:0];
                re_d[bf_bot] = bot_re[W-1:0];
                im_d[bf_bot] = bot_im[W-1:0];
                ovf_d        = ovf_q | bf_clip;
                if (j_q == LAST_J) begin
                    j_d = '0;
                    if (stage_q == LAST_STAGE) begin
                        stage_d = '0;
                        state_d = S_UNLOAD;
                    end else begin
                        stage_d = stage_q + 2'd1;
                    end
                end else begin
                    j_d = j_q + ONE;
                end
            end
            S_UNLOAD: begin
                // Entry cycle primes the output register with bin 0.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_index_d = '0;
                    out_real_d  = re_q[0];
                    out_imag_d  = im_q[0];
                    out_last_d  = (LAST_N == '0);
                end else if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_index_d = '0;
                        out_real_d  = '0;
                        out_imag_d  = '0;
                        in_ready_d  = 1'b1;
                        state_d     = S_LOAD;
                    end else begin
                        out_index_d = out_index_q + ONE;
                        out_real_d  = re_q[out_index_q + ONE];
                        out_imag_d  = im_q[out_index_q + ONE];
                        out_last_d  = ((out_index_q + ONE) == LAST_N);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            j_q         <= '0;
            stage_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_index_q <= '0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            j_q         <= j_d;
            stage_q     <= stage_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_index_q <= out_index_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        re_q <= re_d;
        im_q <= im_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_index = out_index_q;
    assign out_real  = out_real_q;
    assign out_imag  = out_imag_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_radix2_fft_stream.sv
`default_nettype none
// ============================================================================
// tb_radix2_fft_stream : directed frames for the 8-point default build
// Rev 1.0
// ============================================================================
module tb_radix2_fft_stream;
    localparam int W     = 16;
    localparam int LOG2N = 3;
    localparam int N     = 8;

    logic             CLK       = 1'b0;
    logic             RST_N     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [W-1:0]     in_real   = '0;
    logic [W-1:0]     in_imag   = '0;
    logic             in_ready, out_valid, out_last, ovf;
    logic [W-1:0]     out_real, out_imag;
    logic [LOG2N-1:0] out_index;

    int   total = 0;
    int   bad   = 0;
    int   x_re[N], x_im[N], e_re[N], e_im[N];
    int   lat;
    logic ovf_at_first;

    always #5 CLK = ~CLK;

    radix2_fft_stream #(.W(W), .LOG2N(LOG2N)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag),
        .out_index(out_index), .out_last(out_last), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input bit gaps);
        int  guard;
        bit  ok;
        for (int i = 0; i < N; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            in_valid = 1'b1;
            in_real  = W'(x_re[i]);
            in_imag  = W'(x_im[i]);
            ok       = 1'b0;
            guard    = 0;
            while (!ok && guard < 200) begin
                ok = in_ready;
                tick();
                guard++;
            end
            if (!ok) chk("in_ready_timeout", 0, 1);
            if (i == 0) ovf_at_first = ovf;
            in_valid = 1'b0;
        end
    endtask

    task automatic recv_frame(input bit bp, input string tag);
        int k;
        int guard;
        k     = 0;
        guard = 0;
        while (k < N && guard < 500) begin
            out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_valid) begin
                chk({tag, "_index"}, out_index, k);
                chk({tag, "_real"}, $signed(out_real), e_re[k]);
                chk({tag, "_imag"}, $signed(out_imag), e_im[k]);
                chk({tag, "_last"}, out_last, (k == N - 1) ? 1 : 0);
                if (out_ready) k++;
            end
            tick();
            guard++;
        end
        chk({tag, "_bins_seen"}, k, N);
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, out_valid, 0);
        chk({tag, "_post_ready"}, in_ready, 1);
    endtask

    task automatic set_impulse();
        for (int i = 0; i < N; i++) begin
            x_re[i] = (i == 0) ? 1000 : 0;
            x_im[i] = 0;
            e_re[i] = 1000;
            e_im[i] = 0;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_out_real", out_real, 0);
        chk("rst_out_index", out_index, 0);
        RST_N = 1'b1;
        tick();
        chk("rel_in_ready", in_ready, 1);

        // Impulse plus frame latency
        set_impulse();
        send_frame(1'b0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("imp_latency", lat, 13);
        chk("imp_ovf", ovf, 0);
        recv_frame(1'b0, "imp");

        // DC
        for (int i = 0; i < N; i++) begin
            x_re[i] = 1000; x_im[i] = 0;
            e_re[i] = (i == 0) ? 8000 : 0; e_im[i] = 0;
        end
        send_frame(1'b1);
        recv_frame(1'b0, "dc");

        // Alternating sign
        for (int i = 0; i < N; i++) begin
            x_re[i] = (i % 2 == 0) ? 1000 : -1000; x_im[i] = 0;
            e_re[i] = (i == 4) ? 8000 : 0; e_im[i] = 0;
        end
        send_frame(1'b0);
        recv_frame(1'b1, "alt");

        // x1 = 1000: every twiddle used, with gaps and backpressure
        x_re = '{0, 1000, 0, 0, 0, 0, 0, 0};
        x_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        e_re = '{1000, 707, 0, -708, -1000, -707, 0, 708};
        e_im = '{0, -708, -1000, -708, 0, 708, 1000, 708};
        send_frame(1'b1);
        recv_frame(1'b1, "tw_re");

        // x1 = 1000j
        x_re = '{0, 0, 0, 0, 0, 0, 0, 0};
        x_im = '{0, 1000, 0, 0, 0, 0, 0, 0};
        e_re = '{0, 707, 1000, 707, 0, -707, -1000, -707};
        e_im = '{1000, 707, 0, -708, -1000, -707, 0, 708};
        send_frame(1'b0);
        recv_frame(1'b1, "tw_im");

        // Full-scale DC saturates
        for (int i = 0; i < N; i++) begin
            x_re[i] = 32767; x_im[i] = 0;
            e_re[i] = (i == 0) ? 32767 : 0; e_im[i] = 0;
        end
        send_frame(1'b0);
        recv_frame(1'b0, "sat");
        chk("sat_ovf_held", ovf, 1);

        // Next frame clears ovf on its first input
        set_impulse();
        send_frame(1'b0);
        chk("ovf_clear_first", ovf_at_first, 0);
        recv_frame(1'b0, "post_sat");
        chk("post_sat_ovf", ovf, 0);

        // Reset pulse during COMPUTE
        for (int i = 0; i < N; i++) begin
            x_re[i] = 1000; x_im[i] = 0;
        end
        send_frame(1'b0);
        repeat (4) tick();
        RST_N = 1'b0;
        tick();
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        RST_N = 1'b1;
        tick();
        chk("mid_rel_in_ready", in_ready, 1);
        chk("mid_rel_out_valid", out_valid, 0);
        set_impulse();
        send_frame(1'b1);
        recv_frame(1'b1, "fresh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
